// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the 1011 sync-word serial link: FSM state
// encodings and the default sync word, used by both the transmitter and
// the sequence detector.
package seq_fsm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_PARITY = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SYNC   = ST_SYNC,
    DATA   = ST_DATA,
    PARITY = ST_PARITY
  } tx_state_t;

  localparam int SYNC_W_DEF = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN_DEF = 4'b1011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tx_piso.sv
// Parallel-in / serial-out register for the frame payload. Loads a whole
// word, then shifts left one bit per shift strobe; msb is the next bit out.
module frame_tx_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] shift_reg;

  // Load has priority; a reset discards any held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= d;
    end else if (shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  assign msb = shift_reg[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends SYNC_PATTERN MSB-first followed by the
// data word MSB-first on a registered d_out. Words arrive on a valid/ready
// handshake that is only open in IDLE, so frames are always separated by
// at least one idle bit.
// Optional build macro SEQ_FRAME_TX_PARITY_EN appends one even-parity bit.
//
// The outputs are registered from the next-state decode, so the bit for a
// state appears in the same cycle the state register holds it. The PISO
// shifts on the same edge its msb is captured into d_out, so its msb is
// always the next data bit still to be sent.
module seq_frame_tx
  import seq_fsm_pkg::*;
#(
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int                DATA_W       = 8,
  parameter logic              IDLE_BIT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d_out,
  output logic              d_out_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(max_int(SYNC_W, DATA_W) + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             d_out_reg, d_out_next;
  logic             d_out_en_reg, d_out_en_next;
  logic             frame_done_reg, frame_done_next;
  logic             load, shift, piso_msb;

`ifdef SEQ_FRAME_TX_PARITY_EN
  logic             parity_reg;
`endif

  frame_tx_piso #(.DATA_W(DATA_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .d    (tx_data),
    .msb  (piso_msb)
  );

  // State, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      d_out_reg      <= IDLE_BIT;
      d_out_en_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      d_out_reg      <= d_out_next;
      d_out_en_reg   <= d_out_en_next;
      frame_done_reg <= frame_done_next;
    end
  end

`ifdef SEQ_FRAME_TX_PARITY_EN
  // Even parity of the accepted word, captured alongside the PISO load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^tx_data;
    end
  end
`endif

  // Next-state sequencing, then the output bits that state will carry.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    load            = 1'b0;
    shift           = 1'b0;
    d_out_next      = IDLE_BIT;
    d_out_en_next   = 1'b0;
    frame_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          state_next = SYNC;
          cnt_next   = SYNC_LAST;
          load       = 1'b1;
        end
      end
      SYNC: begin
        if (cnt_reg == '0) begin
          state_next = DATA;
          cnt_next   = DATA_LAST;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      PARITY: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      SYNC: begin
        d_out_next    = |(SYNC_PATTERN & (SYNC_ONE << cnt_next));
        d_out_en_next = 1'b1;
      end
      DATA: begin
        d_out_next    = piso_msb;
        d_out_en_next = 1'b1;
        shift         = 1'b1;
`ifndef SEQ_FRAME_TX_PARITY_EN
        frame_done_next = (cnt_next == '0);
`endif
      end
      PARITY: begin
`ifdef SEQ_FRAME_TX_PARITY_EN
        d_out_next      = parity_reg;
        d_out_en_next   = 1'b1;
        frame_done_next = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign d_out      = d_out_reg;
  assign d_out_en   = d_out_en_reg;
  assign frame_done = frame_done_reg;
  assign busy       = (state_reg != IDLE);
  assign tx_ready   = (state_reg == IDLE);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx: a queue-based frame model checked every
// cycle, plus directed frames with hand-written bit patterns.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, d_out, d_out_en, busy, frame_done;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  seq_frame_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .d_out     (d_out),
    .d_out_en  (d_out_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Frame pattern: 12-bit sync+data base, with the parity bit appended
  // only when the parity build is active.
  function automatic logic [31:0] frame_lit(input logic [11:0] base, input logic par);
    logic [31:0] v;
    v = 32'({base, par});
    return v >> (13 - FRAME_LEN);
  endfunction

  // ---------------- behavioural model ----------------
  bit   model_q[$];
  logic exp_d = 1'b0, exp_en = 1'b0, exp_done = 1'b0;
  int   acc_cnt = 0;

  task automatic push_frame(input logic [7:0] w);
    logic [3:0] s;
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) model_q.push_back(s[i]);
    for (int i = 7; i >= 0; i--) model_q.push_back(w[i]);
`ifdef SEQ_FRAME_TX_PARITY_EN
    model_q.push_back(^w);
`endif
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      exp_d    <= 1'b0;
      exp_en   <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      if (!exp_en && tx_valid) begin
        push_frame(tx_data);
        acc_cnt <= acc_cnt + 1;
      end
      if (model_q.size() > 0) begin
        exp_d    <= model_q.pop_front();
        exp_en   <= 1'b1;
        exp_done <= (model_q.size() == 0);
      end else begin
        exp_d    <= 1'b0;
        exp_en   <= 1'b0;
        exp_done <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  logic [31:0] cap = '0;
  int          cap_n = 0, fb_idx = 0, gap_cnt = 0, done_cnt = 0, done_idx = 0;
  int          det_cnt = 0, det_idx = 0, ready_rise = 0;
  logic [3:0]  hist = '0;
  logic        ready_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("d_out", d_out, exp_d);
      chk("d_out_en", d_out_en, exp_en);
      chk("frame_done", frame_done, exp_done);
      chk("busy", busy, exp_en);
      chk("tx_ready", tx_ready, !exp_en);
      if (tx_ready && !ready_prev) ready_rise++;
      ready_prev = tx_ready;
    end
    if (d_out_en) begin
      cap = {cap[30:0], d_out};
      cap_n++;
      fb_idx++;
    end else begin
      fb_idx = 0;
      gap_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      done_idx = fb_idx;
    end
    hist = {hist[2:0], d_out};
    if (hist == 4'b1011) begin
      det_cnt++;
      det_idx = fb_idx;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_acc();
    int a0, n;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("accept_seen", 32'(acc_cnt != a0), 32'd1);
  endtask

  task automatic wait_done_to(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 80) begin
      tick(1);
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic send(input logic [7:0] w);
    int d0;
    d0 = done_cnt;
    tx_data  = w;
    tx_valid = 1'b1;
    wait_acc();
    tx_valid = 1'b0;
    wait_done_to(d0 + 1);
    tick(2);
  endtask

  function automatic logic [31:0] cap_frame();
    return cap & ((32'd1 << FRAME_LEN) - 32'd1);
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int n0, d0, g0, r0, det0, n;

    // Reset state
    tick(2);
    chk("rst_d_out", d_out, 1'b0);
    chk("rst_d_out_en", d_out_en, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("post_rst_tx_ready", tx_ready, 1'b1);
    tick(2);

    // Test 1: single frame A5
    n0 = cap_n;
    send(8'hA5);
    chk("t1_bits", cap_frame(), frame_lit(12'b1011_1010_0101, 1'b0));
    chk("t1_en_len", 32'(cap_n - n0), 32'(FRAME_LEN));
    chk("t1_done_pos", 32'(done_idx), 32'(FRAME_LEN));
    chk("t1_idle_d_out", d_out, 1'b0);
    $display("tx A5 bits=%0b", cap_frame());

`ifdef SEQ_FRAME_TX_PARITY_EN
    // Test 2: parity bit
    send(8'h03);
    chk("t2_par03", cap_frame(), 32'b1011_00000011_0);
    $display("tx 03 bits=%0b", cap_frame());
    send(8'h07);
    chk("t2_par07", cap_frame(), 32'b1011_00000111_1);
    chk("t2_par07_last", cap[0], 1'b1);
    $display("tx 07 bits=%0b", cap_frame());
`endif

    // Test 3: tx_valid held for three words
    d0 = done_cnt;
    r0 = ready_rise;
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    wait_acc();
    g0 = gap_cnt;
    tx_data = 8'h22;
    wait_acc();
    tx_data = 8'h33;
    wait_acc();
    tx_valid = 1'b0;
    wait_done_to(d0 + 3);
    chk("t3_gaps", 32'(gap_cnt - g0), 32'd2);
    chk("t3_frames", 32'(done_cnt - d0), 32'd3);
    tick(2);
    chk("t3_ready_pulses", 32'(ready_rise - r0), 32'd3);
    chk("t3_last_bits", cap_frame(), frame_lit(12'b1011_0011_0011, 1'b0));
    $display("tx 11/22/33 done=%0d", done_cnt - d0);

    // Test 4: asynchronous reset on the 6th frame bit
    d0 = done_cnt;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_acc();
    tx_valid = 1'b0;
    n = 0;
    while (fb_idx != 6 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t4_reached_bit6", 32'(fb_idx), 32'd6);
    #2 rst = 1'b0;
    #1;
    chk("t4_async_d_out", d_out, 1'b0);
    chk("t4_async_en", d_out_en, 1'b0);
    chk("t4_async_done", frame_done, 1'b0);
    chk("t4_async_busy", busy, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h96);
    chk("t4_restart_bits", cap_frame(), frame_lit(12'b1011_1001_0110, 1'b0));
    $display("tx 96 after abort bits=%0b", cap_frame());

    // Test 5: 1011 detector on the looped-back stream
    tick(5);
    det0 = det_cnt;
    send(8'h00);
    chk("t5_detects", 32'(det_cnt - det0), 32'd1);
    chk("t5_detect_pos", 32'(det_idx), 32'd4);
    $display("tx 00 detects=%0d at bit %0d", det_cnt - det0, det_idx);

    // Test 6: input churn during a frame
    d0 = done_cnt;
    tx_data  = 8'h5C;
    tx_valid = 1'b1;
    wait_acc();
    for (int i = 0; i < 8; i++) begin
      tick(1);
      tx_data  = 8'($urandom);
      tx_valid = ~tx_valid;
    end
    tx_valid = 1'b0;
    wait_done_to(d0 + 1);
    tick(2);
    chk("t6_bits", cap_frame(), frame_lit(12'b1011_0101_1100, 1'b0));
    $display("tx 5C with churn bits=%0b", cap_frame());

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
